// File: rtl/rand_pkg.sv
// Encodings, defaults and sizing helpers shared by the random engine controller and the word packer.
package rand_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Same encoding that the engine controller uses for its own FSM.
  typedef enum logic {
    STATE_WAIT = 1'b0,
    STATE_LFSR = 1'b1
  } rand_state_t;

  // Number of bits needed to count 0..n-1. Never returns 0, so n=1 still gets one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rand_word_fifo.sv
// Synchronous word FIFO. Enqueue takes effect on the next edge, and a new word is visible on deq_dat one cycle after it is written.
// enq_rdy stays high while the FIFO is full if a dequeue happens in the same cycle. clear has priority over any enqueue or dequeue.
module rand_word_fifo
  import rand_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = cnt_width(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enq_val,
  output logic             enq_rdy,
  input  logic [WIDTH-1:0] enq_dat,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] deq_dat,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             enq_fire;
  logic             deq_fire;

  assign deq_val  = (level != '0);
  assign deq_fire = deq_val & deq_rdy;
  // A dequeue in the same cycle frees the slot, so a full FIFO can still accept a word.
  assign enq_rdy  = (level != LW'(DEPTH)) | deq_fire;
  assign enq_fire = enq_val & enq_rdy;
  assign deq_dat  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enq_fire && !clear) begin
      mem[wr_ptr] <= enq_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rand_word_packer.sv
// Packs the qualified LFSR bit stream MSB-first into WIDTH-bit words. A word appears on out_data one cycle after its last bit is captured.
// Words leave over out_val/out_rdy. A word that completes while the FIFO is full and not draining is dropped, and the sticky overflow flag is set.
module rand_word_packer
  import rand_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = cnt_width(WIDTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_val,
  input  logic             bit_in,
  input  logic             clear,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             overflow
);

  // Only WIDTH-1 bits need storing, because the final bit of a word goes straight into the FIFO.
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             enq_rdy;

  assign word      = {shreg, bit_in};
  assign word_done = bit_val & (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      shreg    <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (bit_val) begin
        shreg <= word[WIDTH-2:0];
        cnt   <= word_done ? '0 : cnt + CW'(1);
      end
      if (word_done && !enq_rdy) overflow <= 1'b1;
    end
  end

  rand_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .enq_val (word_done),
    .enq_rdy (enq_rdy),
    .enq_dat (word),
    .deq_val (out_val),
    .deq_rdy (out_rdy),
    .deq_dat (out_data),
    .level   (level)
  );

endmodule

// File: tb/tb_rand_word_packer.sv
// Bench for rand_word_packer: directed cases plus a long random run, all checked against a queue-based word model.
module tb_rand_word_packer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_val;
  logic          bit_in;
  logic          clear;
  logic          out_rdy;
  logic          out_val;
  logic [W-1:0]  out_data;
  logic [LW-1:0] level;
  logic          overflow;

  rand_word_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_val  (bit_val),
    .bit_in   (bit_in),
    .clear    (clear),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the bits collected so far, the words the FIFO should hold, and the sticky flag.
  int sb_q[$];
  int m_acc;
  int m_cnt;
  int m_level;
  bit m_ovf;
  bit mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_cnt   = 0;
    m_level = 0;
    m_ovf   = 0;
    sb_q.delete();
  endtask

  // Monitor: checks the outputs against the model on every falling edge. On each handshake it retires the head word.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("level", 32'(level), 32'(m_level));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("out_val", 32'(out_val), 32'(m_level != 0));
      if (out_val) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", out_data, $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(sb_q[0]));
          if (out_rdy) void'(sb_q.pop_front());
        end
      end
    end
  end

  // Applies one cycle of inputs, then advances the model across the clock edge that samples them.
  task automatic step(input bit bv, input bit b, input bit rdy, input bit clr);
    bit deq;
    bit enq;
    bit_val = bv;
    bit_in  = b;
    out_rdy = rdy;
    clear   = clr;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      deq = (m_level > 0) && rdy;
      enq = 0;
      if (bv) begin
        m_acc = (m_acc * 2 + int'(b)) % (1 << W);
        m_cnt++;
        if (m_cnt == W) begin
          if (m_level < D || deq) begin
            sb_q.push_back(m_acc);
            enq = 1;
          end else begin
            m_ovf = 1;
          end
          m_cnt = 0;
          m_acc = 0;
        end
      end
      m_level = m_level + int'(enq) - int'(deq);
    end
    #1;
  endtask

  task automatic send_word(input int w, input bit rdy);
    for (int i = W - 1; i >= 0; i--) step(1'b1, 1'(w >> i), rdy, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int exp_words[4];
    int b2;
    b2      = 'hB2;
    rst     = 1'b1;
    bit_val = 1'b0;
    bit_in  = 1'b0;
    clear   = 1'b0;
    out_rdy = 1'b0;
    mon_en  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val", 32'(out_val), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // The first bit becomes the MSB: 1,0,1,1,0,0,1,0 packs to 0xB2.
    send_word('hB2, 1'b0);
    chk("basic_val", 32'(out_val), 1);
    chk("basic_data", 32'(out_data), 'hB2);
    chk("basic_level", 32'(level), 1);
    drain(2);

    // Idle cycles are interleaved with the valid bits. No word may appear before the eighth valid bit.
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 6 || i == 4 || i == 1) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("gap_no_word", 32'(out_val), 0);
      end
      step(1'b1, 1'(b2 >> i), 1'b0, 1'b0);
      if (i != 0) chk("gap_no_word", 32'(out_val), 0);
    end
    chk("gap_data", 32'(out_data), 'hB2);
    drain(2);

    // Five words arrive while nothing is drained, so the fifth word is dropped.
    for (int k = 1; k <= 5; k++) send_word(k, 1'b0);
    chk("fill_level", 32'(level), 4);
    chk("fill_overflow", 32'(overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("fill_drain_order", 32'(out_data), 32'(k));
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("fill_empty", 32'(out_val), 0);
    chk("fill_ovf_sticky", 32'(overflow), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_ovf", 32'(overflow), 0);

    // The FIFO is full, and a dequeue happens on the same edge as the eighth bit of 0xAA.
    for (int k = 0; k < 4; k++) send_word('h10 + k, 1'b0);
    for (int i = W - 1; i >= 0; i--) step(1'b1, 1'(32'hAA >> i), (i == 0), 1'b0);
    chk("fullsim_level", 32'(level), 4);
    chk("fullsim_overflow", 32'(overflow), 0);
    exp_words = '{'h11, 'h12, 'h13, 'hAA};
    for (int k = 0; k < 4; k++) begin
      chk("fullsim_drain", 32'(out_data), 32'(exp_words[k]));
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("fullsim_empty", 32'(out_val), 0);

    // clear wins over a bit capture and a dequeue that fall on the same edge.
    send_word('h21, 1'b0);
    send_word('h22, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_level", 32'(level), 0);
    chk("clear_out_val", 32'(out_val), 0);
    chk("clear_overflow", 32'(overflow), 0);
    send_word('h5C, 1'b0);
    chk("clear_one_word", 32'(level), 1);
    chk("clear_data", 32'(out_data), 'h5C);
    drain(2);

    // Reset is asserted between edges after one stored word and five bits of a partial word.
    send_word('h3E, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_out_val", 32'(out_val), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_overflow", 32'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word('h96, 1'b0);
    chk("arst_level_after", 32'(level), 1);
    chk("arst_data_after", 32'(out_data), 'h96);
    drain(2);

    // Random run with bursty bits, random backpressure and an occasional clear.
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 199) == 0));
    end
    drain(D + 2);
    chk("final_empty", 32'(out_val), 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_word_packer.md
Name: rand_word_packer

Overview:
- Downstream consumer of the random engine. Takes the one-bit-per-cycle LFSR stream, qualified by the engine's lfsr_en, and packs it into WIDTH-bit words.
- Completed words are buffered in a small FIFO and delivered to the host or consumer over a val/rdy handshake.
- Reports occupancy and a sticky overflow flag so software knows when the engine outran the consumer.

Parameters:
- WIDTH, 8, output word width in bits (2..32).
- DEPTH, 4, FIFO depth in words (power of two, 2..16).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- bit_val  input  1  stream bit valid; tied to the controller's lfsr_en.
- bit_in  input  1  current LFSR output bit.
- clear  input  1  synchronous flush of partial word, FIFO and overflow flag.
- out_val  output  1  a packed word is available at out_data.
- out_rdy  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  head-of-FIFO word.
- level  output  $clog2(DEPTH+1)  number of words held, 0..DEPTH.
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst=1): shift register = 0, bit counter = 0, FIFO empty, read/write pointers = 0, out_val = 0, out_data = 0, level = 0, overflow = 0.
- Packing: on each edge with bit_val=1, shreg <= {shreg[WIDTH-2:0], bit_in} and cnt <= cnt+1. The first bit received ends up as the MSB.
- Word completion: a word completes when bit_val=1 and cnt==WIDTH-1. The word {shreg[WIDTH-2:0], bit_in} is offered to the FIFO and cnt wraps to 0.
- bit_val=0: shreg and cnt hold. A partial word survives a stop/start of the engine.
- Latency: a completed word is visible on out_data with out_val=1 in the cycle after the edge that captured its last bit.
- Output handshake: out_val = (level != 0) and out_data = the head entry.
  - A dequeue occurs on an edge where out_val & out_rdy.
  - out_data must be stable while out_val=1 and out_rdy=0.
- FIFO full, no dequeue that cycle: the completed word is dropped and overflow <= 1. cnt still wraps to 0. Stored words are untouched.
- FIFO full with simultaneous dequeue and completion: the enqueue is accepted, level stays DEPTH, and there is no overflow.
- Empty FIFO with simultaneous completion and out_rdy=1: no dequeue that cycle (out_val=0), so no bypass path. The word appears the next cycle.
- level arithmetic:
  - level increments on enqueue only.
  - level decrements on dequeue only.
  - level is unchanged on both or neither.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- clear=1 (synchronous):
  - cnt, shreg, pointers, level and overflow all go to 0.
  - clear has priority over any same-cycle bit capture, enqueue or dequeue.
  - The out_val=0 that follows is legal even with out_rdy asserted.
- overflow clears only on rst or clear.
- Reset mid-word or mid-handshake: everything returns to reset values immediately (async). No word is emitted.

Decomposition:
- Shared package rand_pkg holds:
  - default WIDTH/DEPTH constants;
  - the packer counter width function (clog2).
- The same package also holds STATE_WAIT/STATE_LFSR, so the engine controller and this block share encodings.
- One sub-module, rand_word_fifo: a parameterised synchronous FIFO with enq_val/enq_rdy and deq_val/deq_rdy, plus level, clear, and the full-with-dequeue enqueue rule.
- The packer top contains only shreg, cnt, the overflow flag and glue.

Test Plan:
- Basic pack (WIDTH=8, DEPTH=4): drive bit_val=1 with bits 1,0,1,1,0,0,1,0 and out_rdy=0 -> one cycle after the 8th bit, out_val=1, out_data=0xB2, level=1.
- Gapped input: the same 8 bits with bit_val=0 on 3 interleaved cycles -> out_data=0xB2 still. No word is emitted before the 8th valid bit; cnt holds across the gaps.
- Fill and overflow: out_rdy=0, stream 5 words 0x01,0x02,0x03,0x04,0x05 -> level=4 and overflow=1 after the 5th word. Draining yields 0x01..0x04 in order, then out_val=0.
- Full with simultaneous dequeue: level=4, the 8th bit of 0xAA arrives while out_rdy=1 -> level stays 4, overflow stays 0, and 0xAA is the last word drained.
- Clear priority: level=2 with 3 partial bits, then assert clear while out_rdy=1 and bit_val=1 -> next cycle level=0, out_val=0, overflow=0. The next 8 bits produce exactly one word.
- Async reset mid-word: assert rst between clock edges after 5 bits with level=1 -> outputs go to 0 immediately without waiting for an edge. After release, 8 new bits give exactly that word.
